ca90_im_bind_bundler: RTL and testbench
=======================================

// Module: ca90_im_bind_bundler
//
// PURPOSE
// - Downstream consumer of the CA90 item memory's two read ports (A/B HVs).
// - Per accepted item: bind A and B (bitwise XOR) or pass A alone.
// - Bundles the items in per-dimension signed saturating counters.
// - On the item flagged last, emits the majority (sign) HV over a valid/ready port.
//
// PARAMETERS
// - HVDimension   512  HV width in bits; must match the item memory output width.
// - CounterWidth  8    Width of each signed per-dimension counter and of item_cnt_o (>=2).
//
// PORTS
// - clk_i        in   1            Clock.
// - rst_i        in   1            Synchronous, active-high reset.
// - im_a_i       in   HVDimension  Item HV A (item memory port A).
// - im_b_i       in   HVDimension  Item HV B (item memory port B).
// - bind_en_i    in   1            1: item = im_a_i ^ im_b_i; 0: item = im_a_i.
// - last_i       in   1            Accepted item closes the bundle.
// - in_valid_i   in   1            Item valid.
// - in_ready_o   out  1            Item ready.
// - clr_i        in   1            Synchronous abort; discards the partial bundle.
// - out_hv_o     out  HVDimension  Bundled (majority) HV.
// - out_valid_o  out  1            Output valid.
// - out_ready_i  in   1            Output ready.
// - item_cnt_o   out  CounterWidth Items in the current bundle; saturates at all-ones.
// - sat_o        out  1            Sticky flag: some counter hit a limit in this bundle.
//
// BEHAVIOUR
// - Reset (rst_i=1 at a clock edge):
//   - state=ACCUM; all counters=0; item_cnt_o=0; sat_o=0.
//   - out_valid_o=0; out_hv_o=0; in_ready_o=1 from the next cycle.
// - Transfer rule: a transfer occurs when valid&&ready at the clock edge.
//   - valid must not depend on ready; ready may depend on valid.
// - FSM has two states:
//   - ACCUM: in_ready_o=1, out_valid_o=0.
//     - Item accepted: for each bit d, cnt[d] += item[d] ? +1 : -1.
//     - Counter limits: saturate at +(2^(CW-1)-1) and -(2^(CW-1)-1).
//     - Hitting or holding a limit sets sat_o.
//     - item_cnt_o += 1 (saturating).
//     - Accept with last_i=1 -> DONE.
//   - DONE: in_ready_o=0, out_valid_o=1; counters frozen.
//     - out_hv_o[d] = (cnt[d] > 0); tie handling (cnt[d]==0) is set under CONFIGURATION.
//     - Output accepted -> ACCUM, with counters, item_cnt_o and sat_o cleared in that same edge.
// - Latency: item accepted with last_i at edge N -> out_valid_o=1 after edge N.
//   - out_hv_o includes that item.
//   - out_hv_o and out_valid_o hold stable until accepted.
// - In DONE, out_hv_o is driven combinationally from the frozen counters.
//   - Outside DONE it is 0.
// - Simultaneous events:
//   - clr_i beats everything except rst_i: resets counters, item_cnt_o and sat_o.
//     - FSM -> ACCUM; out_valid_o=0 next cycle.
//     - Any item offered in the same cycle is dropped (not counted).
//   - clr_i in DONE discards the pending output; no transfer occurs even if out_ready_i=1.
//   - rst_i at any point (mid-bundle or DONE) behaves exactly as reset.
// - Boundaries:
//   - A single-item bundle outputs that item exactly.
//   - last_i is ignored when in_valid_i=0.
//
// CONFIGURATION
// - Macro: HV_BUNDLE_TIE_BREAK_EN
// - Defined:
//   - An HVDimension register captures the first item of each bundle.
//   - Capture happens when item_cnt_o==0 at acceptance.
//   - Tie: out_hv_o[d] = first_item[d].
//   - The register is cleared by rst_i/clr_i.
// - Undefined: tie -> out_hv_o[d]=0; no extra register is built.
//
// TESTING
// - Reset sequence -> in_ready_o=1, out_valid_o=0, item_cnt_o=0, sat_o=0, out_hv_o=0.
// - Single item, bind_en_i=1, im_a_i=0xF0..F0, im_b_i=0xFF..FF, last_i=1:
//   - 1 cycle later out_valid_o=1, out_hv_o=0x0F..0F, item_cnt_o=1.
//   - Hold out_ready_i=0 for 5 cycles -> out_hv_o stable and in_ready_o=0.
// - Three items, bind_en_i=0, A=0x..FF, 0x..0F, 0x..00:
//   - out_hv_o low byte=0x0F; upper bits=0.
// - Two items, A=all-ones then all-zeros:
//   - Macro undefined -> out_hv_o=0.
//   - Macro defined -> out_hv_o=all-ones.
// - CounterWidth=4, 9 items of all-ones then last:
//   - sat_o=1, item_cnt_o=9, out_hv_o=all-ones.
//   - Output accepted -> sat_o=0, item_cnt_o=0.
// - clr_i mid-bundle, with an item offered in the same cycle (after 3 items):
//   - item_cnt_o=0 next cycle.
//   - A following single last item X yields out_hv_o=X.
//   - Repeat with clr_i in DONE with out_ready_i=1 -> no output transfer.

Source files
------------

// File: rtl/ca90_im_bind_bundler.sv
`default_nettype none
// ============================================================================
// Module   : ca90_im_bind_bundler
// Purpose  : Consumes the CA90 item memory's A/B read ports. Each accepted
//            item is either A^B (bind_en_i=1) or A alone, and is bundled into
//            per-dimension signed saturating counters. The item flagged last
//            closes the bundle; the majority (sign) HV is then offered on a
//            valid/ready output port until accepted.
// Ports    : clk_i, rst_i (sync, active-high)
//            im_a_i, im_b_i, bind_en_i, last_i, in_valid_i / in_ready_o
//            clr_i        synchronous abort of the current bundle
//            out_hv_o, out_valid_o / out_ready_i
//            item_cnt_o   items in current bundle (saturating)
//            sat_o        sticky: a counter reached a limit in this bundle
// Option   : HV_BUNDLE_TIE_BREAK_EN - ties (counter == 0) resolve to the
//            first item of the bundle instead of 0.
// Revision : 1.0 - initial release
// ============================================================================
module ca90_im_bind_bundler #(
  parameter int HVDimension  = 512,
  parameter int CounterWidth = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [HVDimension-1:0]  im_a_i,
  input  logic [HVDimension-1:0]  im_b_i,
  input  logic                    bind_en_i,
  input  logic                    last_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    clr_i,
  output logic [HVDimension-1:0]  out_hv_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [CounterWidth-1:0] item_cnt_o,
  output logic                    sat_o
);

  // Counters are symmetric: the most negative code is never used.
  localparam int MAX_VAL = (1 << (CounterWidth - 1)) - 1;
  localparam logic signed [CounterWidth-1:0] CNT_MAX      = CounterWidth'(MAX_VAL);
  localparam logic signed [CounterWidth-1:0] CNT_MIN      = CounterWidth'(-MAX_VAL);
  localparam logic signed [CounterWidth-1:0] CNT_NEAR_MAX = CounterWidth'(MAX_VAL - 1);
  localparam logic signed [CounterWidth-1:0] CNT_NEAR_MIN = CounterWidth'(1 - MAX_VAL);
  localparam logic [CounterWidth-1:0]        ONE          = CounterWidth'(1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [CounterWidth-1:0] item_cnt_q;
  logic                    sat_q;

  logic [HVDimension-1:0]  item;
  logic [HVDimension-1:0]  hit;
  logic [HVDimension-1:0]  maj;
  logic                    accept;
  logic                    release_out;
  logic                    clear_bundle;

  assign item = bind_en_i ? (im_a_i ^ im_b_i) : im_a_i;

  // clr_i wins over both handshakes: a dropped item is not counted and a
  // pending output is discarded without a transfer.
  assign accept       = in_ready_q & in_valid_i & ~clr_i;
  assign release_out  = out_valid_q & out_ready_i & ~clr_i;
  assign clear_bundle = clr_i | release_out;

  // --------------------------------------------------------------------------
  // Control FSM with registered handshake outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid_i && last_i) begin
            state_q     <= DONE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bundle bookkeeping: item count and sticky saturation flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_bundle) begin
      item_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else if (accept) begin
      if (item_cnt_q != '1) begin
        item_cnt_q <= item_cnt_q + ONE;
      end
      if (|hit) begin
        sat_q <= 1'b1;
      end
    end
  end

`ifdef HV_BUNDLE_TIE_BREAK_EN
  // First item of the bundle, used to break ties in the majority vote.
  logic [HVDimension-1:0] first_item_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_bundle) begin
      first_item_q <= '0;
    end else if (accept && (item_cnt_q == '0)) begin
      first_item_q <= item;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Per-dimension saturating counters and majority decision
  // --------------------------------------------------------------------------
  for (genvar d = 0; d < HVDimension; d++) begin : g_dim
    logic signed [CounterWidth-1:0] cnt_q;
    logic                           pos;

    always_ff @(posedge clk_i) begin
      if (rst_i || clear_bundle) begin
        cnt_q <= '0;
      end else if (accept) begin
        if (item[d]) begin
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + ONE;
          end
        end else begin
          if (cnt_q != CNT_MIN) begin
            cnt_q <= cnt_q - ONE;
          end
        end
      end
    end

    // The counter ends this update at a limit: either it steps onto the
    // limit from one code away, or it is already there and holds.
    assign hit[d] = item[d] ? (cnt_q >= CNT_NEAR_MAX) : (cnt_q <= CNT_NEAR_MIN);

    assign pos = ~cnt_q[CounterWidth-1] & (|cnt_q);

`ifdef HV_BUNDLE_TIE_BREAK_EN
    assign maj[d] = pos | (~(|cnt_q) & first_item_q[d]);
`else
    assign maj[d] = pos;
`endif
  end : g_dim

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_hv_o    = maj & {HVDimension{out_valid_q}};
  assign item_cnt_o  = item_cnt_q;
  assign sat_o       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_ca90_im_bind_bundler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ca90_im_bind_bundler
// Purpose  : Self-checking bench for ca90_im_bind_bundler. A driver issues
//            directed and random items, keeps a bundle-level reference model
//            (list of accepted items, evaluated with integer arithmetic) and
//            pushes each expected output into a scoreboard queue. A monitor
//            on the falling edge pops and compares whenever the DUT presents
//            an output, and checks the handshake/status outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ca90_im_bind_bundler;

  localparam int W   = 64;
  localparam int CW  = 4;
  localparam int MAXV = (1 << (CW - 1)) - 1;
  localparam int CNT_SAT = (1 << CW) - 1;

  typedef struct packed {
    logic [W-1:0]  hv;
    logic [CW-1:0] cnt;
    logic          sat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  im_a, im_b;
  logic          bind_en, last, in_valid, in_ready, clr;
  logic [W-1:0]  out_hv;
  logic          out_valid, out_ready;
  logic [CW-1:0] item_cnt;
  logic          sat;

  ca90_im_bind_bundler #(
    .HVDimension (W),
    .CounterWidth(CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .im_a_i     (im_a),
    .im_b_i     (im_b),
    .bind_en_i  (bind_en),
    .last_i     (last),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .clr_i      (clr),
    .out_hv_o   (out_hv),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .item_cnt_o (item_cnt),
    .sat_o      (sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0]  bundle_q[$];
  exp_t          exp_q[$];
  logic          m_done    = 1'b0;
  logic          exp_valid = 1'b0;
  logic [CW-1:0] exp_cnt   = '0;
  logic          exp_sat   = 1'b0;
  logic          mon_en    = 1'b0;

  // Monitor state
  exp_t cur;
  logic have_cur = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Evaluate the current bundle from its item list: each dimension is a
  // running vote clamped to +/-MAXV, sign gives the majority bit.
  function automatic exp_t eval_bundle();
    exp_t e;
    int   c;
    e.hv  = '0;
    e.sat = 1'b0;
    for (int d = 0; d < W; d++) begin
      c = 0;
      foreach (bundle_q[i]) begin
        c += bundle_q[i][d] ? 1 : -1;
        if (c > MAXV)  c = MAXV;
        if (c < -MAXV) c = -MAXV;
        if (c == MAXV || c == -MAXV) e.sat = 1'b1;
      end
      if (c > 0) e.hv[d] = 1'b1;
`ifdef HV_BUNDLE_TIE_BREAK_EN
      else if (c == 0 && bundle_q.size() > 0) e.hv[d] = bundle_q[0][d];
`endif
    end
    e.cnt = CW'((bundle_q.size() > CNT_SAT) ? CNT_SAT : bundle_q.size());
    return e;
  endfunction

  // One clock edge: update the model from the inputs seen at this edge.
  task automatic tick();
    exp_t e;
    logic [W-1:0] it;
    @(posedge clk);
    if (rst || clr) begin
      m_done = 1'b0;
      bundle_q.delete();
    end else if (m_done) begin
      if (out_ready) begin
        m_done = 1'b0;
        bundle_q.delete();
      end
    end else if (in_valid) begin
      it = bind_en ? (im_a ^ im_b) : im_a;
      bundle_q.push_back(it);
      if (last) begin
        exp_q.push_back(eval_bundle());
        m_done = 1'b1;
      end
    end
    e         = eval_bundle();
    exp_cnt   = e.cnt;
    exp_sat   = e.sat;
    exp_valid = m_done;
    #1;
  endtask

  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic be, input logic lst);
    im_a = a; im_b = b; bind_en = be; last = lst; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; last = 1'b0;
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_hv(input int mode);
    case (mode)
      0:       return '1;
      1:       return '0;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", W'(out_valid), W'(exp_valid));
      check("in_ready",  W'(in_ready),  W'(!exp_valid));
      check("item_cnt",  W'(item_cnt),  W'(exp_cnt));
      check("sat",       W'(sat),       W'(exp_sat));
      if (out_valid === 1'b1) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none at %0t", out_hv, $time);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) check("out_hv", out_hv, cur.hv);
      end else begin
        check("out_hv_idle", out_hv, '0);
      end
      if (have_cur && (rst || clr || (out_valid && out_ready))) have_cur = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [W-1:0] x;
  exp_t         ee;

  initial begin
    rst = 1'b1; clr = 1'b0; im_a = '0; im_b = '0; bind_en = 1'b0;
    last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single bound item: F0.. ^ FF.. = 0F..
    offer({8{8'hF0}}, {8{8'hFF}}, 1'b1, 1'b1);
    @(negedge clk);
    check("single_bind_hv",  out_hv, {8{8'h0F}});
    check("single_bind_cnt", W'(item_cnt), W'(1));
    repeat (5) tick();
    check("stall_hv",    out_hv, {8{8'h0F}});
    check("stall_ready", W'(in_ready), W'(0));
    accept_out();

    // Three unbound items: low byte majority of FF, 0F, 00 is 0F
    offer(W'(8'hFF), '1, 1'b0, 1'b0);
    offer(W'(8'h0F), '1, 1'b0, 1'b0);
    offer(W'(8'h00), '1, 1'b0, 1'b1);
    @(negedge clk);
    check("three_items_hv", out_hv, W'(8'h0F));
    accept_out();

    // Tie: all-ones then all-zeros
    offer('1, '0, 1'b0, 1'b0);
    offer('0, '0, 1'b0, 1'b1);
    @(negedge clk);
`ifdef HV_BUNDLE_TIE_BREAK_EN
    check("tie_hv", out_hv, '1);
`else
    check("tie_hv", out_hv, '0);
`endif
    accept_out();

    // Saturation: 9 all-ones items with CW=4 (limit 7)
    for (int i = 0; i < 9; i++) offer('1, '0, 1'b0, (i == 8));
    @(negedge clk);
    check("sat_flag", W'(sat), W'(1));
    check("sat_cnt",  W'(item_cnt), W'(9));
    check("sat_hv",   out_hv, '1);
    accept_out();
    @(negedge clk);
    check("sat_cleared", W'(sat), W'(0));
    check("cnt_cleared", W'(item_cnt), W'(0));

    // clr mid-bundle with an item offered in the same cycle
    for (int i = 0; i < 3; i++) offer(rand_hv(2), '0, 1'b0, 1'b0);
    clr = 1'b1;
    offer('1, '0, 1'b0, 1'b1);
    clr = 1'b0;
    @(negedge clk);
    check("clr_cnt", W'(item_cnt), W'(0));
    x = rand_hv(2);
    offer(x, '0, 1'b0, 1'b1);
    @(negedge clk);
    check("after_clr_hv", out_hv, x);
    accept_out();

    // clr in DONE with out_ready=1: output discarded, no transfer
    offer(rand_hv(2), '0, 1'b0, 1'b0);
    offer(rand_hv(2), '0, 1'b0, 1'b1);
    clr = 1'b1; out_ready = 1'b1;
    tick();
    clr = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("clr_done_valid", W'(out_valid), W'(0));
    x = rand_hv(2);
    offer(x, rand_hv(2), 1'b0, 1'b1);
    @(negedge clk);
    check("after_clr_done_hv", out_hv, x);
    accept_out();

    // Random bundles with gaps, stalls, aborts and resets
    for (int n = 0; n < 150; n++) begin
      int len, mode;
      len  = $urandom_range(1, 20);
      mode = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) begin
          last = $urandom_range(0, 1);   // ignored while in_valid=0
          tick();
          last = 1'b0;
        end
        clr = ($urandom_range(0, 39) == 0);
        rst = ($urandom_range(0, 79) == 0);
        offer(rand_hv(mode), rand_hv(2), $urandom_range(0, 1), (i == len - 1));
        clr = 1'b0; rst = 1'b0;
      end
      repeat ($urandom_range(0, 3)) begin
        in_valid = $urandom_range(0, 1);  // offered while busy: not accepted
        im_a = rand_hv(2);
        tick();
        in_valid = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) clr = 1'b1;
      accept_out();
      clr = 1'b0;
    end

    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || have_cur) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
